// File: rtl/bcd_to_bin_seq_if.sv
// Handshake and data bundle between a BCD source and the converter.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) ();
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (output start, bcd_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; outputs hold the last result
// S_SHIFT  | one shift-right/subtract-3 iteration per clock; an operand
//          | with a non-decimal digit leaves here on its first cycle
// S_FINISH | publish bin_out/err, pulse done, drop busy
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic            clk,
  input  logic            rst,
  bcd_to_bin_seq_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int W     = BCD_W + BIN_W;
  localparam int CW    = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             errf_q, errf_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  function automatic logic any_bad(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      if (v[4*d +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Shift first, then correct each digit of the shifted BCD field.
  function automatic logic [W-1:0] shift_fix(input logic [W-1:0] v);
    logic [W-1:0] s;
    s = v >> 1;
    for (int d = 0; d < DIGITS; d++)
      if (s[BIN_W+4*d +: 4] >= 4'd8)
        s[BIN_W+4*d +: 4] = s[BIN_W+4*d +: 4] - 4'd3;
    return s;
  endfunction

  // State and datapath registers; reset clears any result in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      errf_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      errf_q  <= errf_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    errf_d  = errf_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_d  = {bus.bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
          errf_d  = any_bad(bus.bcd_in);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A bad operand spends exactly one cycle here, giving it a fixed
        // two-clock turnaround without running the shift loop.
        if (errf_q) begin
          state_d = S_FINISH;
        end else begin
          work_d = shift_fix(work_q);
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_W - 1)) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        bin_d   = errf_q ? '0 : work_q[BIN_W-1:0];
        err_d   = errf_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: accepted operands push an expected
// result; a monitor pops and compares on every done pulse.
module tb_bcd_to_bin_seq;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int W      = 4 * DIGITS + BIN_W;

  typedef struct {
    int unsigned bin;
    bit          err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_acc = 0;
  int   last_acc = 0;
  int   last_done = 0;
  int unsigned hold_bin = 0;
  bit   hold_err = 1'b0;
  exp_t sb[$];

  bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal value from digit weights; any digit above 9 is an error.
  function automatic exp_t model(input logic [15:0] v);
    exp_t e;
    int unsigned val;
    int unsigned dig;
    bit bad;
    val = 0;
    bad = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dig = (int'(v) >> (4 * d)) & 15;
      if (dig > 9) bad = 1'b1;
      val = val * 10 + dig;
    end
    e.bin = bad ? 0 : val;
    e.err = bad;
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int x;
    r = '0;
    x = n;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Acceptance: an edge with start high while not busy takes the operand.
  always @(posedge clk) begin
    if (!rst && bus.start && !bus.busy) begin
      exp_t e;
      e = model(bus.bcd_in);
      e.acc = cyc + 1;
      sb.push_back(e);
      last_acc = cyc + 1;
      n_acc++;
    end
  end

  // Monitor: compare results on done, and check held outputs while idle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bin_out", int'(bus.bin_out), e.bin);
          chk("err", int'(bus.err), int'(e.err));
          chk("latency", cyc - e.acc, e.err ? 2 : 15);
          chk("busy_at_done", int'(bus.busy), 0);
          if (!e.err) begin
            checks++;
            assert (dut.work_q[W-1:BIN_W] == '0)
            else begin
              failures++;
              $display("FAIL bcd_field_zero actual=%0h expected=0", dut.work_q[W-1:BIN_W]);
            end
          end
          hold_bin = e.bin;
          hold_err = e.err;
          last_done = cyc;
        end
      end else if (!bus.busy) begin
        chk("hold_bin", int'(bus.bin_out), hold_bin);
        chk("hold_err", int'(bus.err), int'(hold_err));
      end
    end
  end

  task automatic issue(input logic [15:0] v);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("issue_timeout", 1, 0);
    bus.bcd_in = v;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !bus.busy) return;
      @(negedge clk);
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 60; i++) begin
      if (n_acc >= target) return;
      @(negedge clk);
    end
    chk("accept_timeout", n_acc, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [15:0] v;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bcd_in = '0;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_bin", int'(bus.bin_out), 0);
    chk("rst_err", int'(bus.err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h1234); wait_idle();
    chk("bin_1234", int'(bus.bin_out), 1234);
    issue(16'h9999); wait_idle();
    chk("bin_9999", int'(bus.bin_out), 9999);
    issue(16'h0000); wait_idle();
    issue(16'h12A4); wait_idle();
    chk("err_12A4", int'(bus.err), 1);
    issue(16'h0042); wait_idle();
    chk("bin_0042", int'(bus.bin_out), 42);

    // Start held high across two conversions; bcd_in changes mid-conversion.
    n0 = n_acc;
    bus.bcd_in = 16'h0001;
    bus.start  = 1'b1;
    wait_acc(n0 + 1);
    bus.bcd_in = 16'h0010;
    wait_acc(n0 + 2);
    chk("b2b_gap", last_acc, last_done + 1);
    bus.start = 1'b0;
    wait_idle();
    chk("bin_0010", int'(bus.bin_out), 10);

    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        v = 16'($urandom);
      end else begin
        for (int d = 0; d < DIGITS; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      issue(v);
    end
    wait_idle();

    // Reset five edges into a conversion.
    issue(16'h5678);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_bin", int'(bus.bin_out), 0);
    chk("mid_rst_err", int'(bus.err), 0);
    sb.delete();
    hold_bin = 0;
    hold_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'h5678); wait_idle();
    chk("bin_5678", int'(bus.bin_out), 5678);

    for (int i = 0; i < 10000; i += 7) issue(to_bcd(i));
    issue(to_bcd(9998));
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
